// File: rtl/mem_stall_pkg.sv
// Shared types and helpers for the multi-cycle byte-addressable memory (mem_stall_syn).
package mem_stall_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

  // One bit wider than any address so the range check never wraps.
  function automatic logic addr_err(input logic [32:0] a, input int unsigned bpw,
                                    input int unsigned depth);
    logic [33:0] w_end;
    w_end = 34'(a) + 34'(bpw);
    return ((a % 33'(bpw)) != 33'd0) || (w_end > 34'(depth));
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with BPW big-endian write lanes and a combinational multi-byte read.
// With MEM_PARITY_EN a per-byte even-parity shadow is kept and checked on read.
module mem_byte_array
  import mem_stall_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IDX_W       = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
`ifdef MEM_PARITY_EN
  input  logic              i_inj_par,
  output logic              o_par_err,
`endif
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned BPW = bytes_per_word(DATA_W);

  logic [7:0]       r_mem [DEPTH_BYTES];
  logic [IDX_W-1:0] w_idx [BPW];

  always_comb begin
    for (int i = 0; i < BPW; i++) begin
      w_idx[i] = i_addr + IDX_W'(i);
    end
  end

  // Lane 0 carries the MSB byte and lands at the lowest address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BPW; i++) begin
        r_mem[w_idx[i]] <= i_wdata[DATA_W-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < BPW; i++) begin
      o_rdata[DATA_W-1-8*i -: 8] = r_mem[w_idx[i]];
    end
  end

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BPW; i++) begin
        r_par[w_idx[i]] <= (^i_wdata[DATA_W-1-8*i -: 8]) ^ (i_inj_par && (i == 0));
      end
    end
  end

  always_comb begin
    o_par_err = 1'b0;
    for (int i = 0; i < BPW; i++) begin
      o_par_err = o_par_err | ((^r_mem[w_idx[i]]) ^ r_par[w_idx[i]]);
    end
  end
`endif

endmodule

// File: rtl/mem_stall_syn.sv
// Multi-cycle big-endian memory with req/done handshake, alignment and range error flag.
// Optional MEM_PARITY_EN adds per-byte parity and the inj_par_err input.
module mem_stall_syn
  import mem_stall_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
`ifdef MEM_PARITY_EN
  input  logic              inj_par_err,
`endif
  output logic              req_ready,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  localparam int unsigned BPW   = bytes_per_word(DATA_W);
  localparam int unsigned CNT_W = cnt_width(LATENCY);
  localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_wr, w_wr;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_dout, w_rdata;
  logic              r_err;
  logic              w_enter_done, w_addr_err, w_we, w_par_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && req_valid) begin
        r_wr    <= wr;
        r_addr  <= addr;
        r_wdata <= data_in;
      end
    end
  end

  // With LATENCY==1 the DONE edge is the accept edge, so use the live inputs while IDLE.
  assign w_wr    = (r_state == IDLE) ? wr      : r_wr;
  assign w_addr  = (r_state == IDLE) ? addr    : r_addr;
  assign w_wdata = (r_state == IDLE) ? data_in : r_wdata;

  assign w_addr_err   = addr_err(33'(w_addr), BPW, DEPTH_BYTES);
  assign w_enter_done = (w_state_nxt == DONE) && !rst;
  assign w_we         = w_enter_done && w_wr && !w_addr_err;

`ifdef MEM_PARITY_EN
  logic r_inj, w_inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj <= 1'b0;
    end else if (r_state == IDLE && req_valid) begin
      r_inj <= inj_par_err;
    end
  end

  assign w_inj = (r_state == IDLE) ? inj_par_err : r_inj;
`endif

  mem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_addr    (w_addr[IDX_W-1:0]),
    .i_wdata   (w_wdata),
`ifdef MEM_PARITY_EN
    .i_inj_par (w_inj),
    .o_par_err (w_par_err),
`endif
    .o_rdata   (w_rdata)
  );

`ifndef MEM_PARITY_EN
  assign w_par_err = 1'b0;
`endif

  // Response registers hold their value only for the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_err  <= 1'b0;
    end else if (w_enter_done) begin
      r_dout <= (w_wr || w_addr_err) ? '0 : w_rdata;
      r_err  <= w_addr_err || (!w_wr && w_par_err);
    end else begin
      r_dout <= '0;
      r_err  <= 1'b0;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign done      = (r_state == DONE);
  assign data_out  = r_dout;
  assign err       = r_err;

endmodule
